// File: rtl/hazard_detection_unit.sv
// Hazard qualifiers for the stage stall/flush controller: load-use, branch-in-flight, delayed branch, miss.
// Optional HAZARD_STATS_EN adds saturating 32-bit stall/miss counters.
`timescale 1ns/1ps
module hazard_detection_unit #(
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned WATCHDOG_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      decodeValid,
    input  logic                      decodeIsBranch,
    input  logic                      decodeUsesRs1,
    input  logic                      decodeUsesRs2,
    input  logic [REG_ADDR_WIDTH-1:0] decodeRs1,
    input  logic [REG_ADDR_WIDTH-1:0] decodeRs2,
    input  logic                      executeValid,
    input  logic                      executeIsLoad,
    input  logic                      executeWritesRd,
    input  logic [REG_ADDR_WIDTH-1:0] executeRd,
    input  logic                      branchResolved,
    input  logic                      branchMispredicted,
    output logic                      isDataHazard,
    output logic                      isBranchHazard,
    output logic                      isBranchHazardDelayed,
    output logic                      isMiss,
    output logic                      hazardTimeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]               dataStallCount,
    output logic [31:0]               branchStallCount,
    output logic [31:0]               missCount
`endif
);

    localparam int unsigned CNT_W = $clog2(WATCHDOG_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT_RESOLVE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_timeout_set;
    logic             r_timeout;
    logic             r_bh_dly;

    logic w_miss;
    logic w_dep;
    logic w_data;
    logic w_branch_start;
    logic w_bh;

    always_comb begin
        w_miss = branchResolved & branchMispredicted;
        w_dep  = (decodeUsesRs1 && (decodeRs1 == executeRd)) ||
                 (decodeUsesRs2 && (decodeRs2 == executeRd));
        w_data = decodeValid & executeValid & executeIsLoad & executeWritesRd &
                 (executeRd != '0) & w_dep & ~w_miss;
        w_branch_start = decodeValid & decodeIsBranch & ~w_data & ~w_miss;
        // A branch entering decode stalls fetch immediately, including the re-arm case.
        w_bh = ((r_state == S_WAIT_RESOLVE) & ~branchResolved) | w_branch_start;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_timeout_set)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_branch_start) begin
                    w_state_nxt = S_WAIT_RESOLVE;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_RESOLVE: begin
                if (w_miss) begin
                    w_state_nxt = S_IDLE;
                end else if (branchResolved) begin
                    if (w_branch_start)
                        w_cnt_nxt = '0;
                    else
                        w_state_nxt = S_IDLE;
                end else begin
                    if (r_cnt != '1)
                        w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WATCHDOG_CYCLES - 1))
                        w_timeout_set = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            r_bh_dly <= 1'b0;
        else
            r_bh_dly <= w_bh & ~w_miss;
    end

    // Combinational qualifiers are forced low while reset is asserted.
    always_comb begin
        isDataHazard          = rstN & w_data;
        isBranchHazard        = rstN & w_bh;
        isMiss                = rstN & w_miss;
        isBranchHazardDelayed = r_bh_dly;
        hazardTimeout         = r_timeout;
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_data_cnt;
    logic [31:0] r_branch_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_data_cnt   <= '0;
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (w_data && (r_data_cnt != '1))
                r_data_cnt <= r_data_cnt + 32'd1;
            if (w_bh && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_miss && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    always_comb begin
        dataStallCount   = r_data_cnt;
        branchStallCount = r_branch_cnt;
        missCount        = r_miss_cnt;
    end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit; expected output vectors are {data, branch, branchDly, miss, timeout}.
`timescale 1ns/1ps
module tb_hazard_detection_unit;

    typedef struct packed {
        logic       dv;
        logic       dbr;
        logic       u1;
        logic       u2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ev;
        logic       eld;
        logic       ewr;
        logic [4:0] erd;
        logic       res;
        logic       mis;
    } in_t;

    logic       clk;
    logic       rstN;
    logic       decodeValid, decodeIsBranch, decodeUsesRs1, decodeUsesRs2;
    logic [4:0] decodeRs1, decodeRs2;
    logic       executeValid, executeIsLoad, executeWritesRd;
    logic [4:0] executeRd;
    logic       branchResolved, branchMispredicted;
    logic       isDataHazard, isBranchHazard, isBranchHazardDelayed, isMiss, hazardTimeout;
`ifdef HAZARD_STATS_EN
    logic [31:0] dataStallCount, branchStallCount, missCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] sb[$];

    hazard_detection_unit #(
        .REG_ADDR_WIDTH (5),
        .WATCHDOG_CYCLES(64)
    ) dut (
        .clk                  (clk),
        .rstN                 (rstN),
        .decodeValid          (decodeValid),
        .decodeIsBranch       (decodeIsBranch),
        .decodeUsesRs1        (decodeUsesRs1),
        .decodeUsesRs2        (decodeUsesRs2),
        .decodeRs1            (decodeRs1),
        .decodeRs2            (decodeRs2),
        .executeValid         (executeValid),
        .executeIsLoad        (executeIsLoad),
        .executeWritesRd      (executeWritesRd),
        .executeRd            (executeRd),
        .branchResolved       (branchResolved),
        .branchMispredicted   (branchMispredicted),
        .isDataHazard         (isDataHazard),
        .isBranchHazard       (isBranchHazard),
        .isBranchHazardDelayed(isBranchHazardDelayed),
        .isMiss               (isMiss),
        .hazardTimeout        (hazardTimeout)
`ifdef HAZARD_STATS_EN
        ,
        .dataStallCount       (dataStallCount),
        .branchStallCount     (branchStallCount),
        .missCount            (missCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic in_t s_idle();
        in_t s = '0;
        return s;
    endfunction

    function automatic in_t s_br();
        in_t s = '0;
        s.dv  = 1'b1;
        s.dbr = 1'b1;
        return s;
    endfunction

    function automatic in_t s_res(input logic mis);
        in_t s = '0;
        s.res = 1'b1;
        s.mis = mis;
        return s;
    endfunction

    function automatic in_t s_lu(input logic [4:0] erd, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2);
        in_t s = '0;
        s.dv  = 1'b1;
        s.ev  = 1'b1;
        s.eld = 1'b1;
        s.ewr = 1'b1;
        s.erd = erd;
        s.rs1 = rs1;
        s.u1  = u1;
        s.rs2 = rs2;
        s.u2  = u2;
        return s;
    endfunction

    function automatic logic [4:0] outs();
        return {isDataHazard, isBranchHazard, isBranchHazardDelayed, isMiss, hazardTimeout};
    endfunction

    task automatic drive(input in_t s);
        decodeValid        = s.dv;
        decodeIsBranch     = s.dbr;
        decodeUsesRs1      = s.u1;
        decodeUsesRs2      = s.u2;
        decodeRs1          = s.rs1;
        decodeRs2          = s.rs2;
        executeValid       = s.ev;
        executeIsLoad      = s.eld;
        executeWritesRd    = s.ewr;
        executeRd          = s.erd;
        branchResolved     = s.res;
        branchMispredicted = s.mis;
    endtask

    // Drive one cycle of stimulus, record its expectation, then move to the sampling point.
    task automatic apply(input in_t s, input logic [4:0] e);
        @(posedge clk);
        #1;
        drive(s);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] got, want;
        rstN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(in_t'(s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0) | s_br() | s_res(1'b1)), 5'b00000);
            got  = outs();
            want = sb.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b expected %b", i, got, want);
            end
        end
        drive(s_idle());
        rstN = 1'b1;
    endtask

    task automatic test_data_hazard();
        in_t st[$];
        logic [4:0] ex[$];
        logic [4:0] got, want;
        in_t t;
        st.push_back(s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0));                 ex.push_back(5'b10000);
        st.push_back(in_t'(s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0) | s_br())); ex.push_back(5'b10000);
        st.push_back(s_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1));                 ex.push_back(5'b00000);
        st.push_back(s_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1));                 ex.push_back(5'b10000);
        st.push_back(s_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b0));                 ex.push_back(5'b00000);
        t = s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); t.eld = 1'b0;
        st.push_back(t);                                                  ex.push_back(5'b00000);
        t = s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); t.ev = 1'b0;
        st.push_back(t);                                                  ex.push_back(5'b00000);
        t = s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); t.ewr = 1'b0;
        st.push_back(t);                                                  ex.push_back(5'b00000);
        st.push_back(in_t'(s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0) | s_res(1'b1))); ex.push_back(5'b00010);
        st.push_back(s_res(1'b0));                                        ex.push_back(5'b00000);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got  = outs();
            want = sb.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL data_hazard[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_branch_resolve();
        in_t st[$];
        logic [4:0] ex[$];
        logic [4:0] got, want;
        st.push_back(s_br());       ex.push_back(5'b01000);
        st.push_back(s_idle());     ex.push_back(5'b01100);
        st.push_back(s_idle());     ex.push_back(5'b01100);
        st.push_back(s_res(1'b0));  ex.push_back(5'b00100);
        st.push_back(s_idle());     ex.push_back(5'b00000);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got  = outs();
            want = sb.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch_resolve[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_mispredict();
        in_t st[$];
        logic [4:0] ex[$];
        logic [4:0] got, want;
        st.push_back(s_br());                          ex.push_back(5'b01000);
        st.push_back(s_idle());                        ex.push_back(5'b01100);
        st.push_back(in_t'(s_res(1'b1) | s_br()));     ex.push_back(5'b00110);
        st.push_back(s_idle());                        ex.push_back(5'b00000);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got  = outs();
            want = sb.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mispredict[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    // Re-arm at cycle 41; if the counter were not restarted the watchdog would fire by cycle 65.
    task automatic test_back_to_back();
        in_t st[$];
        logic [4:0] ex[$];
        logic [4:0] got, want;
        st.push_back(s_br()); ex.push_back(5'b01000);
        for (int k = 1; k <= 40; k++) begin
            st.push_back(s_idle()); ex.push_back(5'b01100);
        end
        st.push_back(in_t'(s_res(1'b0) | s_br())); ex.push_back(5'b01100);
        for (int k = 42; k <= 81; k++) begin
            st.push_back(s_idle()); ex.push_back(5'b01100);
        end
        st.push_back(s_res(1'b0)); ex.push_back(5'b00100);
        st.push_back(s_idle());    ex.push_back(5'b00000);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got  = outs();
            want = sb.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        in_t st[$];
        logic [4:0] ex[$];
        logic [4:0] got, want;
        st.push_back(s_br()); ex.push_back(5'b01000);
        for (int k = 1; k <= 70; k++) begin
            st.push_back(s_idle());
            ex.push_back({4'b0110, (k >= 65) ? 1'b1 : 1'b0});
        end
        st.push_back(s_res(1'b0)); ex.push_back(5'b00101);
        st.push_back(s_idle());    ex.push_back(5'b00001);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got  = outs();
            want = sb.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, got, want);
            end
        end
        @(posedge clk);
        #2;
        rstN = 1'b0;
        sb.push_back(5'b00000);
        #1;
        got  = outs();
        want = sb.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b expected %b", got, want);
        end
        @(negedge clk);
        rstN = 1'b1;
        apply(s_idle(), 5'b00000);
        got  = outs();
        want = sb.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL timeout_after_reset: got %b expected %b", got, want);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] got, want;
        apply(s_br(), 5'b01000);
        got = outs(); want = sb.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_reset_enter: got %b expected %b", got, want);
        end
        apply(s_idle(), 5'b01100);
        got = outs(); want = sb.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_reset_wait: got %b expected %b", got, want);
        end
        @(posedge clk);
        #1;
        drive(in_t'(s_br() | s_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0)));
        #2;
        rstN = 1'b0;
        sb.push_back(5'b00000);
        #1;
        got = outs(); want = sb.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_reset_mid: got %b expected %b", got, want);
        end
        @(negedge clk);
        drive(s_idle());
        rstN = 1'b1;
        apply(s_idle(), 5'b00000);
        got = outs(); want = sb.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_reset_idle: got %b expected %b", got, want);
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        logic [95:0] got, want;
        @(negedge clk);
        rstN = 1'b0;
        #1;
        rstN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), 5'b10000);
            void'(sb.pop_front());
        end
        apply(s_res(1'b1), 5'b00010);
        void'(sb.pop_front());
        apply(s_idle(), 5'b00000);
        void'(sb.pop_front());
        got  = {dataStallCount, branchStallCount, missCount};
        want = {32'd10, 32'd0, 32'd1};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL stats: got %0d/%0d/%0d expected 10/0/1",
                     dataStallCount, branchStallCount, missCount);
        end
    endtask
`endif

    initial begin
        drive(s_idle());
        test_reset();
        test_data_hazard();
        test_branch_resolve();
        test_mispredict();
        test_back_to_back();
        test_timeout();
        test_async_reset();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
